alu_exec_ctrl: RTL and testbench
================================

ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width; legal values are 32 and 64.
REQ-002 SHALL have ports clk_i (in, 1): the single clock, with all state updated on its rising edge.
REQ-003 SHALL have port rst_ni (in, 1): asynchronous, active-low reset.
REQ-004 SHALL have port valid_i (in, 1): request valid.
REQ-005 SHALL have port ready_o (out, 1): unit can accept a request.
REQ-006 SHALL have ports funct3_i (in, 3) and funct7_i (in, 7): RISC-V operation fields.
REQ-007 SHALL have port is_imm_i (in, 1): OP-IMM form.
REQ-008 SHALL have ports a_i and b_i (in, XLEN): operands.
REQ-009 SHALL have port valid_o (out, 1): result valid.
REQ-010 SHALL have port ready_i (in, 1): consumer accepts the result.
REQ-011 SHALL have port result_o (out, XLEN): the result.
REQ-012 SHALL have port illegal_o (out, 1): undecodable operation, qualified by valid_o.
REQ-013 SHALL have port busy_o (out, 1): an iterative operation is in progress.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, CALC, DONE.
- ready_o = (state==IDLE).
- valid_o = (state==DONE).
REQ-015 SHALL accept a request on valid_i && ready_o and latch funct3_i, funct7_i, is_imm_i, a_i and b_i.
REQ-016 SHALL decode operations as follows:
- funct7 0000000: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
- funct7 0100000: only SUB (funct3 000) and SRA (funct3 101).
- funct7 0000001: M-extension operations.
- is_imm_i=1: funct7 ignored except bit 5 selecting SRAI when funct3=101.
REQ-017 SHALL complete base operations and illegal encodings IDLE->DONE: valid_o rises exactly one cycle after acceptance.
REQ-018 SHALL route M operations IDLE->CALC, iterate one bit per cycle for XLEN cycles, then go CALC->DONE: valid_o rises XLEN+1 cycles after acceptance.
REQ-019 SHALL drive busy_o=1 only in CALC.
REQ-020 SHALL hold result_o and illegal_o stable while in DONE, and go DONE->IDLE on ready_i=1; there is no DONE->DONE back-to-back acceptance.
REQ-021 SHALL take the shift amount from b[log2(XLEN)-1:0]; SLT is signed and SLTU unsigned; all arithmetic wraps modulo 2^XLEN.
REQ-022 SHALL compute MUL, MULH, MULHSU and MULHU as follows:
- Form magnitudes per signedness.
- Produce a 2*XLEN product by shift-add.
- Negate when the operand signs differ.
- MUL returns the low half; the others return the high half.
REQ-023 SHALL compute DIV, DIVU, REM and REMU by restoring division on magnitudes; the quotient sign is sign(a)^sign(b) and the remainder takes the sign of a.
REQ-024 SHALL handle divide by zero in one cycle (IDLE->DONE): DIV/DIVU return all-ones and REM/REMU return a.
REQ-025 SHALL handle signed overflow (a=most-negative, b=-1) in one cycle: DIV returns a and REM returns 0.
REQ-026 SHALL report illegal encodings with illegal_o=1 and result_o=0.
REQ-027 SHALL ignore valid_i outside IDLE: no acceptance and no latched-field change.

Reset
REQ-028 SHALL, while rst_ni=0, force:
- state IDLE and the iteration counter to 0;
- valid_o=0, busy_o=0, illegal_o=0, result_o=0;
- ready_o=1 (from the IDLE decode).
REQ-029 SHALL, on reset asserted mid-CALC or in DONE, discard the operation and never produce valid_o for it after reset release.

Configuration
REQ-030 SHALL use macro ALU_EXEC_MULDIV_EN.
- Defined: M-extension operations behave per REQ-018 to REQ-025.
- Undefined: funct7 0000001 is illegal (REQ-026), the CALC state and iterative core are not instantiated, and busy_o is tied to 0.

Structure
REQ-031 SHALL place the following in shared package alu_pkg:
- alu_op_e (decoded operation enum);
- FSM state enum;
- FUNCT7_BASE, FUNCT7_ALT and FUNCT7_MULDIV constants;
- funct3 constants.
REQ-032 SHALL implement iteration in sub-module mdu_iter (start/done, XLEN-parameterised), instantiated only under ALU_EXEC_MULDIV_EN.

Verification
REQ-033 SHALL have the bench cover these directed scenarios:
- SUB, a=5, b=7, XLEN=32 -> valid_o 1 cycle after accept, result 0xFFFFFFFE.
- SRAI, is_imm=1, funct7=0100000, a=0x80000000, b=4 -> 0xF8000000.
- MULHU, a=b=0xFFFFFFFF -> 0xFFFFFFFE after 33 cycles, busy_o high for 32 cycles.
- DIV, a=0x80000000, b=-1 -> 0x80000000 in 1 cycle; DIVU, b=0 -> 0xFFFFFFFF; REM, a=-7, b=2 -> 0xFFFFFFFF.
- ready_i held low 5 cycles in DONE -> result_o stable and ready_o=0; valid_i pulses ignored.
- rst_ni asserted at CALC cycle 10 -> all outputs at reset values, no valid_o after release; without ALU_EXEC_MULDIV_EN, MUL -> illegal_o=1, result 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types, encodings and decode helper for the ALU execution controller.
// Used by alu_exec_ctrl and, when ALU_EXEC_MULDIV_EN is defined, by mdu_iter.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_ILLEGAL
  } alu_op_e;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Base integer funct3 encodings
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // M-extension funct3 encodings
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  function automatic alu_op_e base_op(input logic [2:0] f3, input logic alt_sr);
    alu_op_e op;
    op = OP_ILLEGAL;
    case (f3)
      F3_ADD:  op = OP_ADD;
      F3_SLL:  op = OP_SLL;
      F3_SLT:  op = OP_SLT;
      F3_SLTU: op = OP_SLTU;
      F3_XOR:  op = OP_XOR;
      F3_SR:   op = alt_sr ? OP_SRA : OP_SRL;
      F3_OR:   op = OP_OR;
      F3_AND:  op = OP_AND;
      default: op = OP_ILLEGAL;
    endcase
    return op;
  endfunction

  // The immediate form ignores funct7 apart from bit 5 on shift-right (SRAI).
  function automatic alu_op_e decode_op(input logic [2:0] f3, input logic [6:0] f7,
                                        input logic imm);
    alu_op_e op;
    op = OP_ILLEGAL;
    if (imm) begin
      op = base_op(f3, f7[5]);
    end else if (f7 == FUNCT7_BASE) begin
      op = base_op(f3, 1'b0);
    end else if (f7 == FUNCT7_ALT) begin
      if (f3 == F3_ADD)     op = OP_SUB;
      else if (f3 == F3_SR) op = OP_SRA;
      else                  op = OP_ILLEGAL;
    end else if (f7 == FUNCT7_MULDIV) begin
      case (f3)
        F3_MUL:    op = OP_MUL;
        F3_MULH:   op = OP_MULH;
        F3_MULHSU: op = OP_MULHSU;
        F3_MULHU:  op = OP_MULHU;
        F3_DIV:    op = OP_DIV;
        F3_DIVU:   op = OP_DIVU;
        F3_REM:    op = OP_REM;
        F3_REMU:   op = OP_REMU;
        default:   op = OP_ILLEGAL;
      endcase
    end
    return op;
  endfunction

  function automatic logic is_muldiv(input alu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide core: one bit per cycle for XLEN cycles.
// Built only when ALU_EXEC_MULDIV_EN is defined. Operands and op are held
// stable by the caller for the whole run; the first iteration seeds from them.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  alu_op_e         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int            CW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic            active_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   acc_q;
  logic [XLEN-1:0] lo_q;

  logic            mul_op, a_sgn, b_sgn, neg_a, neg_b, neg_p, first, ge;
  logic [XLEN-1:0] mag_a, mag_b, opnd, lo_init, cur_lo, lo_n;
  logic [XLEN:0]   cur_acc, acc_n, sum, rsh;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quo_s, rem_s;

  assign mul_op = op_i inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  assign a_sgn  = op_i inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign b_sgn  = op_i inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  assign neg_a  = a_sgn & a_i[XLEN-1];
  assign neg_b  = b_sgn & b_i[XLEN-1];
  assign neg_p  = neg_a ^ neg_b;
  assign mag_a  = neg_a ? -a_i : a_i;
  assign mag_b  = neg_b ? -b_i : b_i;

  // Multiply: lo holds the multiplier, opnd the multiplicand.
  // Divide:   lo holds the dividend/quotient, opnd the divisor.
  assign opnd    = mul_op ? mag_a : mag_b;
  assign lo_init = mul_op ? mag_b : mag_a;
  assign first   = (cnt_q == '0);
  assign cur_acc = first ? '0 : acc_q;
  assign cur_lo  = first ? lo_init : lo_q;

  // One shift-add or restoring-division step
  always_comb begin
    sum = cur_acc + (cur_lo[0] ? {1'b0, opnd} : '0);
    rsh = {cur_acc[XLEN-1:0], cur_lo[XLEN-1]};
    ge  = (rsh >= {1'b0, opnd});
    if (mul_op) begin
      acc_n = {1'b0, sum[XLEN:1]};
      lo_n  = {sum[0], cur_lo[XLEN-1:1]};
    end else begin
      acc_n = ge ? (rsh - {1'b0, opnd}) : rsh;
      lo_n  = {cur_lo[XLEN-2:0], ge};
    end
  end

  // Iteration control: counts XLEN steps after start
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
    end else if (active_q) begin
      if (cnt_q == LAST) begin
        active_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Datapath registers advance only while iterating and then hold the answer
  always_ff @(posedge clk_i) begin
    if (active_q) begin
      acc_q <= acc_n;
      lo_q  <= lo_n;
    end
  end

  assign done_o = active_q && (cnt_q == LAST);

  // Sign fix-up of the finished magnitudes
  always_comb begin
    prod     = {acc_q[XLEN-1:0], lo_q};
    prod_s   = neg_p ? -prod : prod;
    quo_s    = neg_p ? -lo_q : lo_q;
    rem_s    = neg_a ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    result_o = '0;
    case (op_i)
      OP_MUL:                        result_o = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result_o = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               result_o = quo_s;
      OP_REM, OP_REMU:               result_o = rem_s;
      default:                       result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// RISC-V integer execution unit with IDLE/CALC/DONE handshake controller.
// Define ALU_EXEC_MULDIV_EN to add the iterative M-extension (mdu_iter);
// without it funct7=0000001 decodes as illegal and busy_o is tied low.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic            is_imm_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            illegal_o,
  output logic            busy_o
);

  localparam int SHW = $clog2(XLEN);

  state_e          state_q;
  logic [2:0]      f3_q;
  logic [6:0]      f7_q;
  logic            imm_q;
  logic [XLEN-1:0] a_q, b_q;
  alu_op_e         op_q;
  logic            accept, go_calc;
  logic [XLEN-1:0] res_sel;

  // Without the M-extension its encodings are treated as undecodable
  function automatic alu_op_e gate_op(input alu_op_e op);
`ifdef ALU_EXEC_MULDIV_EN
    return op;
`else
    return is_muldiv(op) ? OP_ILLEGAL : op;
`endif
  endfunction

  // Single-cycle results: base ops plus the divide-by-zero / overflow shortcuts
  function automatic logic [XLEN-1:0] alu_fast(input alu_op_e op, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    logic [SHW-1:0]         sh;
    logic [XLEN-1:0]        r;
    sa = a;
    sb = b;
    sh = b[SHW-1:0];
    r  = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLL:  r = a << sh;
      OP_SLT:  r = {{(XLEN-1){1'b0}}, (sa < sb)};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:  r = a ^ b;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = sa >>> sh;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_DIV:  r = (b == '0) ? '1 : a;
      OP_DIVU: r = '1;
      OP_REM:  r = (b == '0) ? a : '0;
      OP_REMU: r = a;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign accept = valid_i && (state_q == ST_IDLE);
  assign op_q   = gate_op(decode_op(f3_q, f7_q, imm_q));

`ifdef ALU_EXEC_MULDIV_EN
  alu_op_e         op_in;
  logic            mdu_done;
  logic [XLEN-1:0] mdu_res;

  // Multiply always iterates; divides skip the core for /0 and signed overflow
  function automatic logic needs_iter(input alu_op_e op, input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
    logic zero, ovf;
    zero = (b == '0);
    ovf  = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    case (op)
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: return 1'b1;
      OP_DIV, OP_REM:                       return !zero && !ovf;
      OP_DIVU, OP_REMU:                     return !zero;
      default:                              return 1'b0;
    endcase
  endfunction

  assign op_in   = gate_op(decode_op(funct3_i, funct7_i, is_imm_i));
  assign go_calc = needs_iter(op_in, a_i, b_i);
  assign res_sel = needs_iter(op_q, a_q, b_q) ? mdu_res : alu_fast(op_q, a_q, b_q);
  assign busy_o  = (state_q == ST_CALC);

  mdu_iter #(
    .XLEN(XLEN)
  ) u_mdu (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (accept && go_calc),
    .op_i    (op_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .done_o  (mdu_done),
    .result_o(mdu_res)
  );
`else
  assign go_calc = 1'b0;
  assign res_sel = alu_fast(op_q, a_q, b_q);
  assign busy_o  = 1'b0;
`endif

  // Controller: IDLE accepts, CALC waits on the core, DONE waits on the consumer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (valid_i) state_q <= go_calc ? ST_CALC : ST_DONE;
`ifdef ALU_EXEC_MULDIV_EN
        ST_CALC: if (mdu_done) state_q <= ST_DONE;
`endif
        ST_DONE: if (ready_i) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Request fields captured only on acceptance; they stay put through CALC and DONE
  always_ff @(posedge clk_i) begin
    if (accept) begin
      f3_q  <= funct3_i;
      f7_q  <= funct7_i;
      imm_q <= is_imm_i;
      a_q   <= a_i;
      b_q   <= b_i;
    end
  end

  // Outputs are qualified by state so reset forces them to zero immediately
  assign ready_o   = (state_q == ST_IDLE);
  assign valid_o   = (state_q == ST_DONE);
  assign illegal_o = valid_o && (op_q == OP_ILLEGAL);
  assign result_o  = valid_o ? res_sel : '0;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed, table-driven bench for alu_exec_ctrl (XLEN=32), with hand-written
// sequences for DONE hold-off and reset during an operation.
module tb_alu_exec_ctrl;

  localparam int XLEN = 32;
`ifdef ALU_EXEC_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid_i, ready_o, valid_o, ready_i;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            is_imm;
  logic [XLEN-1:0] a, b, result;
  logic            illegal, busy;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.XLEN(XLEN)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .funct3_i (funct3),
    .funct7_i (funct7),
    .is_imm_i (is_imm),
    .a_i      (a),
    .b_i      (b),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result),
    .illegal_o(illegal),
    .busy_o   (busy)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          bsy;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                         input logic [31:0] va, input logic [31:0] vb, input logic [31:0] res,
                         input logic ill, input int lat, input int bsy);
    vec_t v;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.a = va; v.b = vb;
    v.res = res; v.ill = ill; v.lat = lat; v.bsy = bsy;
    vecs.push_back(v);
  endtask

  // M-extension row: iterative when built in, otherwise an illegal encoding
  task automatic add_m(input logic [2:0] f3, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] res, input bit iter);
    if (MD) add_vec(f3, 7'b0000001, 1'b0, va, vb, res, 1'b0, iter ? XLEN + 1 : 1, iter ? XLEN : 0);
    else    add_vec(f3, 7'b0000001, 1'b0, va, vb, 32'h0, 1'b1, 1, 0);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                        input logic [31:0] va, input logic [31:0] vb,
                        output logic [31:0] res, output logic ill, output int lat,
                        output int bsy);
    @(negedge clk);
    funct3 = f3; funct7 = f7; is_imm = imm; a = va; b = vb; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 1;
    bsy = 0;
    while (!valid_o && lat < 100) begin
      if (busy) bsy++;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    ill = illegal;
  endtask

  task automatic release_result();
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        il;
    int          lat, bsy, seen;

    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    funct3 = '0; funct7 = '0; is_imm = 1'b0; a = '0; b = '0;

    #12;
    chk("reset ready_o",   32'(ready_o), 32'd1);
    chk("reset valid_o",   32'(valid_o), 32'd0);
    chk("reset busy_o",    32'(busy),    32'd0);
    chk("reset illegal_o", 32'(illegal), 32'd0);
    chk("reset result_o",  result,       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    add_vec(3'b000, 7'h00, 1'b0, 32'd5,        32'd7,        32'd12,       1'b0, 1, 0);
    add_vec(3'b000, 7'h20, 1'b0, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1, 0);
    add_vec(3'b000, 7'h00, 1'b0, 32'hFFFFFFFF, 32'd1,        32'h0,        1'b0, 1, 0);
    add_vec(3'b001, 7'h00, 1'b0, 32'd1,        32'h3F,       32'h80000000, 1'b0, 1, 0);
    add_vec(3'b010, 7'h00, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1, 0);
    add_vec(3'b011, 7'h00, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1, 0);
    add_vec(3'b100, 7'h00, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1, 0);
    add_vec(3'b101, 7'h00, 1'b0, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1, 0);
    add_vec(3'b101, 7'h20, 1'b0, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1, 0);
    add_vec(3'b101, 7'h20, 1'b1, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1, 0);
    add_vec(3'b101, 7'h00, 1'b1, 32'h80000000, 32'h24,       32'h08000000, 1'b0, 1, 0);
    add_vec(3'b000, 7'h20, 1'b1, 32'd5,        32'd7,        32'd12,       1'b0, 1, 0);
    add_vec(3'b110, 7'h00, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1, 0);
    add_vec(3'b111, 7'h00, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1, 0);
    add_vec(3'b001, 7'h20, 1'b0, 32'd3,        32'd4,        32'h0,        1'b1, 1, 0);
    add_vec(3'b000, 7'h7F, 1'b0, 32'd3,        32'd4,        32'h0,        1'b1, 1, 0);
    add_m(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
    add_m(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1);
    add_m(3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b1);
    add_m(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    add_m(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
    add_m(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b0);
    add_m(3'b101, 32'h123,      32'h0,        32'hFFFFFFFF, 1'b0);
    add_m(3'b100, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0);
    add_m(3'b110, 32'h1234,     32'h0,        32'h1234,     1'b0);
    add_m(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b1);
    add_m(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b1);
    add_m(3'b101, 32'd100,      32'd7,        32'd14,       1'b1);
    add_m(3'b111, 32'd100,      32'd7,        32'd2,        1'b1);

    foreach (vecs[i]) begin
      run_op(vecs[i].f3, vecs[i].f7, vecs[i].imm, vecs[i].a, vecs[i].b, r, il, lat, bsy);
      chk($sformatf("vec%0d result", i),  r,        vecs[i].res);
      chk($sformatf("vec%0d illegal", i), 32'(il),  32'(vecs[i].ill));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d busy", i),    32'(bsy), 32'(vecs[i].bsy));
      release_result();
    end

    // Consumer stalls in DONE while new requests are offered
    run_op(3'b000, 7'h20, 1'b0, 32'd5, 32'd7, r, il, lat, bsy);
    chk("hold first result", r, 32'hFFFFFFFE);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      funct3 = 3'b000; funct7 = 7'h00; is_imm = 1'b0; a = 32'd1; b = 32'd1; valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      chk($sformatf("hold%0d result", k),  result,          32'hFFFFFFFE);
      chk($sformatf("hold%0d ready_o", k), 32'(ready_o),    32'd0);
      chk($sformatf("hold%0d valid_o", k), 32'(valid_o),    32'd1);
    end
    release_result();
    chk("after hold ready_o", 32'(ready_o), 32'd1);
    chk("after hold valid_o", 32'(valid_o), 32'd0);
    @(posedge clk); #1;
    chk("no stray accept valid_o", 32'(valid_o), 32'd0);

    // Reset ten cycles into a MULHU (or while its illegal result waits in DONE)
    @(negedge clk);
    funct3 = 3'b011; funct7 = 7'b0000001; is_imm = 1'b0;
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
`ifdef ALU_EXEC_MULDIV_EN
    chk("pre-reset busy_o", 32'(busy), 32'd1);
`else
    chk("pre-reset valid_o", 32'(valid_o), 32'd1);
`endif
    rst_n = 1'b0;
    #1;
    chk("mid reset ready_o",   32'(ready_o), 32'd1);
    chk("mid reset valid_o",   32'(valid_o), 32'd0);
    chk("mid reset busy_o",    32'(busy),    32'd0);
    chk("mid reset illegal_o", 32'(illegal), 32'd0);
    chk("mid reset result_o",  result,       32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o) seen++;
    end
    chk("post-reset valid_o cycles", 32'(seen), 32'd0);

    run_op(3'b000, 7'h00, 1'b0, 32'd2, 32'd3, r, il, lat, bsy);
    chk("post-reset add result",  r,        32'd5);
    chk("post-reset add latency", 32'(lat), 32'd1);
    release_result();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
